// File: rtl/axi4_stream_aligner.sv
// Strips shift_i leading null bytes from the first beat of each AXI4-Stream packet
// and repacks the payload so it starts at byte lane 0, using a one-beat holding buffer.
module axi4_stream_aligner #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH_B_W-1:0] shift_i,
  input  logic [DATA_WIDTH-1:0]     pkt_in_tdata_i,
  input  logic [DATA_WIDTH_B-1:0]   pkt_in_tkeep_i,
  input  logic [DATA_WIDTH_B-1:0]   pkt_in_tstrb_i,
  input  logic                      pkt_in_tlast_i,
  input  logic [ID_WIDTH-1:0]       pkt_in_tid_i,
  input  logic [DEST_WIDTH-1:0]     pkt_in_tdest_i,
  input  logic [USER_WIDTH-1:0]     pkt_in_tuser_i,
  input  logic                      pkt_in_tvalid_i,
  output logic                      pkt_in_tready_o,
  output logic [DATA_WIDTH-1:0]     pkt_out_tdata_o,
  output logic [DATA_WIDTH_B-1:0]   pkt_out_tkeep_o,
  output logic [DATA_WIDTH_B-1:0]   pkt_out_tstrb_o,
  output logic                      pkt_out_tlast_o,
  output logic [ID_WIDTH-1:0]       pkt_out_tid_o,
  output logic [DEST_WIDTH-1:0]     pkt_out_tdest_o,
  output logic [USER_WIDTH-1:0]     pkt_out_tuser_o,
  output logic                      pkt_out_tvalid_o,
  input  logic                      pkt_out_tready_i,
  output logic                      drop_o,
  output logic [1:0]                state_o
);

  // Handshakes: a beat transfers on a rising clk edge where tvalid and tready are both
  // high; tvalid never depends on tready, and a raised tvalid holds until that transfer.

  localparam int LW = DATA_WIDTH_B_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TAIL = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     held_data_q, held_data_d;
  logic [DATA_WIDTH_B_W-1:0] s_q, s_d;
  logic [LW-1:0]             l_q, l_d;
  logic [ID_WIDTH-1:0]       tid_q, tid_d;
  logic [DEST_WIDTH-1:0]     tdest_q, tdest_d;
  logic [USER_WIDTH-1:0]     tuser_q, tuser_d;
  logic                      drop_q, drop_d;

  logic [DATA_WIDTH_B-1:0]   keep_or;
  logic [LW-1:0]             in_len;
  logic [LW-1:0]             shift_ext;
  logic [LW-1:0]             s_ext;
  logic [LW-1:0]             hold_cnt;
  logic [LW-1:0]             tail_cnt;
  logic [DATA_WIDTH-1:0]     merged;
  logic [DATA_WIDTH_B-1:0]   byte_mask;
  logic [DATA_WIDTH-1:0]     bit_mask;
  logic                      in_hs;

  function automatic logic [DATA_WIDTH_B-1:0] low_mask(input logic [LW-1:0] n);
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      low_mask[i] = (i < int'(n));
    end
  endfunction

  // Byte count of the incoming beat; only a tlast beat may be partial.
  always_comb begin
    logic [LW-1:0] pop;
    keep_or = pkt_in_tkeep_i | pkt_in_tstrb_i;
    pop     = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      pop = pop + LW'(keep_or[i]);
    end
    in_len = pkt_in_tlast_i ? pop : LW'(DATA_WIDTH_B);
  end

  assign shift_ext = {1'b0, shift_i};
  assign s_ext     = {1'b0, s_q};
  assign hold_cnt  = LW'(DATA_WIDTH_B) - s_ext + in_len;
  assign tail_cnt  = l_q - s_ext;

  // Upper lanes of the held beat slide down; low lanes of the incoming beat fill the top.
  assign merged = DATA_WIDTH'({pkt_in_tdata_i, held_data_q} >> {s_q, 3'b000});

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
  end

  assign in_hs = pkt_in_tvalid_i & pkt_in_tready_o;

  always_comb begin
    state_d          = state_q;
    held_data_d      = held_data_q;
    s_d              = s_q;
    l_d              = l_q;
    tid_d            = tid_q;
    tdest_d          = tdest_q;
    tuser_d          = tuser_q;
    drop_d           = 1'b0;
    pkt_in_tready_o  = 1'b0;
    pkt_out_tvalid_o = 1'b0;
    pkt_out_tlast_o  = 1'b0;
    byte_mask        = '0;

    case (state_q)
      IDLE: begin
        pkt_in_tready_o = 1'b1;
        if (in_hs) begin
          s_d         = shift_i;
          tid_d       = pkt_in_tid_i;
          tdest_d     = pkt_in_tdest_i;
          tuser_d     = pkt_in_tuser_i;
          held_data_d = pkt_in_tdata_i;
          if (pkt_in_tlast_i && (in_len <= shift_ext)) begin
            drop_d = 1'b1;
          end else if (pkt_in_tlast_i) begin
            l_d     = in_len;
            state_d = TAIL;
          end else begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        pkt_out_tvalid_o = pkt_in_tvalid_i;
        pkt_in_tready_o  = pkt_out_tready_i;
        if (pkt_in_tlast_i && (in_len <= s_ext)) begin
          // Remaining payload fits in one output beat: the packet shrinks by one beat.
          pkt_out_tlast_o = 1'b1;
          byte_mask       = low_mask(hold_cnt);
          if (in_hs) begin
            state_d = IDLE;
          end
        end else begin
          byte_mask = '1;
          if (in_hs) begin
            held_data_d = pkt_in_tdata_i;
            if (pkt_in_tlast_i) begin
              l_d     = in_len;
              state_d = TAIL;
            end
          end
        end
      end

      TAIL: begin
        pkt_out_tvalid_o = 1'b1;
        pkt_out_tlast_o  = 1'b1;
        byte_mask        = low_mask(tail_cnt);
        if (pkt_out_tready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      held_data_q <= '0;
      s_q         <= '0;
      l_q         <= '0;
      tid_q       <= '0;
      tdest_q     <= '0;
      tuser_q     <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_data_q <= held_data_d;
      s_q         <= s_d;
      l_q         <= l_d;
      tid_q       <= tid_d;
      tdest_q     <= tdest_d;
      tuser_q     <= tuser_d;
      drop_q      <= drop_d;
    end
  end

  assign pkt_out_tdata_o = merged & bit_mask;
  assign pkt_out_tkeep_o = byte_mask;
  assign pkt_out_tstrb_o = byte_mask;
  assign pkt_out_tid_o   = tid_q;
  assign pkt_out_tdest_o = tdest_q;
  assign pkt_out_tuser_o = tuser_q;
  assign drop_o          = drop_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_axi4_stream_aligner.sv
// Bench for axi4_stream_aligner: table of packet cases, randomized long packets with
// downstream backpressure, and a mid-packet reset, all checked through an expected queue.
module tb_axi4_stream_aligner;

  localparam int DW = 32;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    shift;
  logic [DW-1:0] in_data;
  logic [B-1:0]  in_keep, in_strb;
  logic          in_last, in_tid, in_tdest, in_tuser, in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic [B-1:0]  out_keep, out_strb;
  logic          out_last, out_tid, out_tdest, out_tuser, out_valid, out_ready;
  logic          drop;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;
  int drop_seen = 0;
  int rdy_mode = 1;       // 0: never ready, 1: always ready, 2: random
  logic chk_ready = 1'b0;
  logic prev_pend = 1'b0;

  // {tid, tdest, tuser, tlast, tkeep, tdata}
  logic [39:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  axi4_stream_aligner #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .shift_i(shift),
    .pkt_in_tdata_i(in_data), .pkt_in_tkeep_i(in_keep), .pkt_in_tstrb_i(in_strb),
    .pkt_in_tlast_i(in_last), .pkt_in_tid_i(in_tid), .pkt_in_tdest_i(in_tdest),
    .pkt_in_tuser_i(in_tuser), .pkt_in_tvalid_i(in_valid), .pkt_in_tready_o(in_ready),
    .pkt_out_tdata_o(out_data), .pkt_out_tkeep_o(out_keep), .pkt_out_tstrb_o(out_strb),
    .pkt_out_tlast_o(out_last), .pkt_out_tid_o(out_tid), .pkt_out_tdest_o(out_tdest),
    .pkt_out_tuser_o(out_tuser), .pkt_out_tvalid_o(out_valid), .pkt_out_tready_i(out_ready),
    .drop_o(drop), .state_o(state)
  );

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b0;
    else if (rdy_mode == 1) out_ready = 1'b1;
    else                    out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [39:0] e;
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) check("valid_held", 64'(out_valid), 64'd1);
      if (chk_ready && state == 2'd1) check("hold_ready", 64'(in_ready), 64'(out_ready));
      if (drop) drop_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected none",
                   {out_tid, out_tdest, out_tuser, out_last, out_keep, out_data});
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 64'({out_tid, out_tdest, out_tuser, out_last, out_keep, out_data}), 64'(e));
        end
      end
      prev_pend = out_valid && !out_ready;
    end
  end

  // driver tasks
  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic id, input logic us, input logic [1:0] sh);
    int   n  = 0;
    logic hs = 1'b0;
    in_data = d; in_keep = k; in_strb = k; in_last = l;
    in_tid = id; in_tdest = id; in_tuser = us; shift = sh; in_valid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no tready expected handshake at %0t", $time);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]       shift;
    int               n_in;
    logic [3:0][31:0] in_data;
    logic [3:0]       last_keep;
    int               n_out;
    logic [3:0][31:0] out_data;
    logic [3:0]       out_last_keep;
    int               drops;
    logic             tid;
    logic             tuser;
  } case_t;

  case_t cases[8];

  task automatic run_case(input int c);
    int   d0 = drop_seen;
    logic lst;
    for (int j = 0; j < cases[c].n_out; j++) begin
      lst = (j == cases[c].n_out - 1);
      exp_q.push_back({cases[c].tid, cases[c].tid, cases[c].tuser, lst,
                       lst ? cases[c].out_last_keep : 4'hF, cases[c].out_data[j]});
    end
    for (int i = 0; i < cases[c].n_in; i++) begin
      lst = (i == cases[c].n_in - 1);
      // later beats carry different sideband and shift, which must be ignored
      send_beat(cases[c].in_data[i], lst ? cases[c].last_keep : 4'hF, lst,
                (i == 0) ? cases[c].tid : ~cases[c].tid,
                (i == 0) ? cases[c].tuser : ~cases[c].tuser,
                (i == 0) ? cases[c].shift : ~cases[c].shift);
    end
    wait_drain();
    check($sformatf("drop_count_case%0d", c), 64'(drop_seen - d0), 64'(cases[c].drops));
  endtask

  task automatic run_random(input logic id, input logic us);
    logic [7:0]  bytes[$];
    logic [31:0] words[10];
    logic [31:0] d;
    logic [3:0]  k, lk;
    int nl, nb, nexp, idx, d0;
    d0 = drop_seen;
    nl = $urandom_range(1, 4);
    lk = 4'((1 << nl) - 1);
    for (int i = 0; i < 10; i++) begin
      words[i] = $urandom;
      nb = (i == 9) ? nl : 4;
      for (int b = 0; b < nb; b++) bytes.push_back(words[i][8*b +: 8]);
    end
    repeat (2) void'(bytes.pop_front());
    nexp = (bytes.size() + 3) / 4;
    for (int j = 0; j < nexp; j++) begin
      d = '0;
      k = '0;
      for (int b = 0; b < 4; b++) begin
        idx = 4 * j + b;
        if (idx < bytes.size()) begin
          d[8*b +: 8] = bytes[idx];
          k[b] = 1'b1;
        end
      end
      exp_q.push_back({id, id, us, (j == nexp - 1), k, d});
    end
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      send_beat(words[i], (i == 9) ? lk : 4'hF, (i == 9), (i == 0) ? id : ~id,
                (i == 0) ? us : ~us, (i == 0) ? 2'd2 : 2'd1);
    end
    wait_drain();
    check("drop_count_random", 64'(drop_seen - d0), 64'd0);
  endtask

  initial begin
    cases[0] = '{shift: 2'd0, n_in: 3, in_data: {32'h0, 32'h0B0A0908, 32'h07060504, 32'h03020100},
                 last_keep: 4'hF, n_out: 3,
                 out_data: {32'h0, 32'h0B0A0908, 32'h07060504, 32'h03020100},
                 out_last_keep: 4'hF, drops: 0, tid: 1'b1, tuser: 1'b0};
    cases[1] = '{shift: 2'd1, n_in: 3, in_data: {32'h0, 32'h0B0A0908, 32'h07060504, 32'h03020100},
                 last_keep: 4'h3, n_out: 3,
                 out_data: {32'h0, 32'h00000009, 32'h08070605, 32'h04030201},
                 out_last_keep: 4'h1, drops: 0, tid: 1'b0, tuser: 1'b1};
    cases[2] = '{shift: 2'd3, n_in: 2, in_data: {32'h0, 32'h0, 32'hAA060504, 32'h03020100},
                 last_keep: 4'h7, n_out: 1,
                 out_data: {32'h0, 32'h0, 32'h0, 32'h06050403},
                 out_last_keep: 4'hF, drops: 0, tid: 1'b1, tuser: 1'b1};
    cases[3] = '{shift: 2'd2, n_in: 1, in_data: {32'h0, 32'h0, 32'h0, 32'h03020100},
                 last_keep: 4'h3, n_out: 0, out_data: {32'h0, 32'h0, 32'h0, 32'h0},
                 out_last_keep: 4'h0, drops: 1, tid: 1'b0, tuser: 1'b0};
    cases[4] = '{shift: 2'd2, n_in: 1, in_data: {32'h0, 32'h0, 32'h0, 32'h03020100},
                 last_keep: 4'hF, n_out: 1, out_data: {32'h0, 32'h0, 32'h0, 32'h00000302},
                 out_last_keep: 4'h3, drops: 0, tid: 1'b1, tuser: 1'b0};
    cases[5] = '{shift: 2'd3, n_in: 1, in_data: {32'h0, 32'h0, 32'h0, 32'h03020100},
                 last_keep: 4'hF, n_out: 1, out_data: {32'h0, 32'h0, 32'h0, 32'h00000003},
                 out_last_keep: 4'h1, drops: 0, tid: 1'b0, tuser: 1'b1};
    cases[6] = '{shift: 2'd1, n_in: 2, in_data: {32'h0, 32'h0, 32'hDDCCBB04, 32'h03020100},
                 last_keep: 4'h1, n_out: 1, out_data: {32'h0, 32'h0, 32'h0, 32'h04030201},
                 out_last_keep: 4'hF, drops: 0, tid: 1'b1, tuser: 1'b1};
    cases[7] = '{shift: 2'd3, n_in: 2, in_data: {32'h0, 32'h0, 32'hEEDD0504, 32'h03020100},
                 last_keep: 4'h3, n_out: 1, out_data: {32'h0, 32'h0, 32'h0, 32'h00050403},
                 out_last_keep: 4'h7, drops: 0, tid: 1'b0, tuser: 1'b0};

    rst = 1'b1;
    shift = '0; in_data = '0; in_keep = '0; in_strb = '0; in_last = 1'b0;
    in_tid = 1'b0; in_tdest = 1'b0; in_tuser = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #3;
    check("reset_tvalid", 64'(out_valid), 64'd0);
    check("reset_tlast", 64'(out_last), 64'd0);
    check("reset_tdata", 64'(out_data), 64'd0);
    check("reset_tkeep", 64'(out_keep), 64'd0);
    check("reset_tstrb", 64'(out_strb), 64'd0);
    check("reset_drop", 64'(drop), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int c = 0; c < 8; c++) run_case(c);

    rdy_mode  = 2;
    chk_ready = 1'b1;
    for (int r = 0; r < 3; r++) run_random(1'(r), 1'(r + 1));
    chk_ready = 1'b0;

    // mid-packet reset while a beat is stalled in HOLD
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_beat(32'h03020100, 4'hF, 1'b0, 1'b1, 1'b0, 2'd2);
    in_data = 32'h07060504; in_keep = 4'hF; in_strb = 4'hF; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_state", 64'(state), 64'd1);
    check("pre_reset_tvalid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_reset_tvalid", 64'(out_valid), 64'd0);
    check("mid_reset_tkeep", 64'(out_keep), 64'd0);
    check("mid_reset_state", 64'(state), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    run_case(1);
    run_case(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
